// File: rtl/sp_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// Each access is IDLE -> ISSUE (-> CAPTURE for reads) -> IDLE, and all outputs are registered.
module sp_ram_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state;
    logic   last_b;     // B was granted most recently
    logic   win_b;      // owner of the access in flight
    logic   cmd_we;
    logic   grant_b_c;

    // B wins when alone, or on contention when A was granted last.
    assign grant_b_c = req_b & (~req_a | ~last_b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            win_b     <= 1'b0;
            cmd_we    <= 1'b0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
            rdata_a   <= '0;
            rdata_b   <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        win_b     <= grant_b_c;
                        last_b    <= grant_b_c;
                        cmd_we    <= grant_b_c ? we_b : we_a;
                        ram_en    <= 1'b1;
                        ram_we    <= grant_b_c ? we_b : we_a;
                        ram_addr  <= grant_b_c ? addr_b : addr_a;
                        ram_wdata <= grant_b_c ? wdata_b : wdata_a;
                        ack_a     <= ~grant_b_c;
                        ack_b     <= grant_b_c;
                    end
                end
                ISSUE: begin
                    if (cmd_we) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (win_b) begin
                        rdata_b  <= ram_rdata;
                        rvalid_b <= 1'b1;
                    end else begin
                        rdata_a  <= ram_rdata;
                        rvalid_a <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural single-port RAM behind it.
module tb_sp_ram_arbiter;

    logic       clk;
    logic       rst;
    logic       req_a, req_b, we_a, we_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       ack_a, ack_b, rvalid_a, rvalid_b;
    logic [7:0] rdata_a, rdata_b;
    logic       ram_en, ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;
    logic       busy;

    logic [7:0] mem [16];
    int tests;
    int failed;

    sp_ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data appears one cycle after issue.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        failed = 0;
        ram_rdata = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h3C ^ 8'(i * 17);
        rst = 1'b0;
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = 4'h0; addr_b = 4'h0; wdata_a = 8'h00; wdata_b = 8'h00;

        // Reset values
        tick(); tick();
        check("rst_busy",   32'(busy),     32'h0);
        check("rst_ram_en", 32'(ram_en),   32'h0);
        check("rst_ack",    32'({ack_a, ack_b}), 32'h0);
        check("rst_rvalid", 32'({rvalid_a, rvalid_b}), 32'h0);
        check("rst_addr",   32'(ram_addr), 32'h0);
        check("rst_wdata",  32'(ram_wdata), 32'h0);
        check("rst_rdata",  32'({rdata_a, rdata_b}), 32'h0);
        rst = 1'b1;
        tick();

        // Single write: A writes 0x5A to address 3
        req_a = 1'b1; we_a = 1'b1; addr_a = 4'd3; wdata_a = 8'h5A;
        tick();
        check("wr_ack_a",  32'(ack_a),     32'h1);
        check("wr_ack_b",  32'(ack_b),     32'h0);
        check("wr_ram_en", 32'(ram_en),    32'h1);
        check("wr_ram_we", 32'(ram_we),    32'h1);
        check("wr_addr",   32'(ram_addr),  32'h3);
        check("wr_wdata",  32'(ram_wdata), 32'h5A);
        check("wr_busy",   32'(busy),      32'h1);
        req_a = 1'b0;
        tick();
        check("wr_idle_en",   32'(ram_en),   32'h0);
        check("wr_idle_ack",  32'(ack_a),    32'h0);
        check("wr_hold_addr", 32'(ram_addr), 32'h3);
        check("wr_idle_busy", 32'(busy),     32'h0);
        check("wr_no_rv1",    32'(rvalid_a), 32'h0);
        tick();
        check("wr_no_rv2",    32'({rvalid_a, rvalid_b}), 32'h0);

        // Single read: B reads address 3
        req_b = 1'b1; we_b = 1'b0; addr_b = 4'd3;
        tick();
        check("rd_ack_b",   32'(ack_b),    32'h1);
        check("rd_ack_a",   32'(ack_a),    32'h0);
        check("rd_ram_we",  32'(ram_we),   32'h0);
        check("rd_addr",    32'(ram_addr), 32'h3);
        req_b = 1'b0;
        tick();
        check("rd_cap_busy", 32'(busy),     32'h1);
        check("rd_cap_rv",   32'(rvalid_b), 32'h0);
        check("rd_cap_en",   32'(ram_en),   32'h0);
        tick();
        check("rd_rvalid_b", 32'(rvalid_b), 32'h1);
        check("rd_rvalid_a", 32'(rvalid_a), 32'h0);
        check("rd_rdata_b",  32'(rdata_b),  32'h5A);
        check("rd_end_busy", 32'(busy),     32'h0);
        tick();
        check("rd_rv_pulse", 32'(rvalid_b), 32'h0);
        check("rd_rdata_hold", 32'(rdata_b), 32'h5A);

        // Contention after reset: A, B, A, B, 2 cycles apart
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        req_a = 1'b1; we_a = 1'b1; addr_a = 4'd5; wdata_a = 8'h11;
        req_b = 1'b1; we_b = 1'b1; addr_b = 4'd6; wdata_b = 8'h22;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ct_ack_a", 32'(ack_a), (i % 2 == 0) ? 32'h1 : 32'h0);
            check("ct_ack_b", 32'(ack_b), (i % 2 == 1) ? 32'h1 : 32'h0);
            check("ct_addr",  32'(ram_addr), (i % 2 == 0) ? 32'h5 : 32'h6);
            if (i == 3) begin
                req_a = 1'b0; req_b = 1'b0;
            end
            tick();
            check("ct_gap_en",  32'(ram_en), 32'h0);
            check("ct_gap_ack", 32'({ack_a, ack_b}), 32'h0);
        end

        // Back-to-back reads by A with req held: addr 0 then addr 15
        req_a = 1'b1; we_a = 1'b0; addr_a = 4'd0;
        tick();
        check("bb_ack1",   32'(ack_a), 32'h1);
        check("bb_busy1",  32'(busy),  32'h1);
        addr_a = 4'd15;
        tick();
        check("bb_cap1_busy", 32'(busy), 32'h1);
        tick();
        check("bb_rv1",    32'(rvalid_a), 32'h1);
        check("bb_data1",  32'(rdata_a),  32'h3C);
        check("bb_idle",   32'(busy),     32'h0);
        tick();
        check("bb_ack2",   32'(ack_a),    32'h1);
        check("bb_addr2",  32'(ram_addr), 32'hF);
        check("bb_rv_off", 32'(rvalid_a), 32'h0);
        check("bb_busy2",  32'(busy),     32'h1);
        req_a = 1'b0;
        tick();
        check("bb_cap2_busy", 32'(busy), 32'h1);
        tick();
        check("bb_rv2",    32'(rvalid_a), 32'h1);
        check("bb_data2",  32'(rdata_a),  32'hC3);

        // Reset during CAPTURE of a B read
        tick();
        req_b = 1'b1; we_b = 1'b0; addr_b = 4'd0;
        tick();
        check("mr_ack_b", 32'(ack_b), 32'h1);
        req_b = 1'b0;
        tick();
        check("mr_cap_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        check("mr_busy",  32'(busy),     32'h0);
        check("mr_addr",  32'(ram_addr), 32'h0);
        check("mr_rdata", 32'({rdata_a, rdata_b}), 32'h0);
        check("mr_ack",   32'({ack_a, ack_b}), 32'h0);
        tick();
        check("mr_no_rv1", 32'({rvalid_a, rvalid_b}), 32'h0);
        rst = 1'b1;
        tick();
        check("mr_no_rv2", 32'({rvalid_a, rvalid_b}), 32'h0);
        req_a = 1'b1; we_a = 1'b1; addr_a = 4'd7; wdata_a = 8'h77;
        req_b = 1'b1; we_b = 1'b1; addr_b = 4'd8; wdata_b = 8'h88;
        tick();
        check("mr_first_a", 32'(ack_a), 32'h1);
        check("mr_first_b", 32'(ack_b), 32'h0);
        req_a = 1'b0; req_b = 1'b0;
        tick();

        // Idle: no requests for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_en",   32'(ram_en), 32'h0);
            check("idle_busy", 32'(busy),   32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sp_ram_arbiter.md
SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 4, RAM address width; DATA_W, default 8, RAM data width.
REQ-002 The block SHALL use one clock and one reset, with reset asynchronous and active-low.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  asynchronous active-low reset.
REQ-005 Ports req_a / req_b  input  1  access request from requester A / B.
REQ-006 Ports we_a / we_b  input  1  1=write, 0=read, for requester A / B.
REQ-007 Ports addr_a / addr_b  input  ADDR_W  access address.
REQ-008 Ports wdata_a / wdata_b  input  DATA_W  write data.
REQ-009 Ports ack_a / ack_b  output  1  one-cycle grant/acceptance pulse.
REQ-010 Ports rdata_a / rdata_b  output  DATA_W  registered read data, held until the next read for that requester.
REQ-011 Ports rvalid_a / rvalid_b  output  1  one-cycle read-data-valid pulse.
REQ-012 Ports ram_en, ram_we  output  1  single-port RAM enable and write strobe.
REQ-013 Ports ram_addr  output  ADDR_W; ram_wdata  output  DATA_W  RAM address and write data.
REQ-014 Port ram_rdata  input  DATA_W  RAM read data, valid one cycle after a read issue.
REQ-015 Port busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE, CAPTURE.
REQ-017 IDLE: if any req is high at a rising edge, the arbiter SHALL latch the winner's we/addr/wdata and go to ISSUE; otherwise it SHALL remain in IDLE.
REQ-018 Arbitration SHALL be round-robin: with both reqs high, the requester not granted last wins; a lone requester always wins.
REQ-019 The last-granted pointer SHALL update only on the IDLE->ISSUE transition.
REQ-020 ISSUE lasts exactly one cycle: ram_en=1, ram_we=latched we, ram_addr/ram_wdata=latched values, and the winner's ack=1.
REQ-021 ISSUE SHALL go to IDLE for a write and to CAPTURE for a read.
REQ-022 CAPTURE lasts one cycle; ram_rdata SHALL be registered into the winner's rdata at its closing edge, and the winner's rvalid SHALL be high the following cycle.
REQ-023 Latency from the edge sampling req in IDLE SHALL be: ack in the next cycle; rvalid 3 cycles after that edge.
REQ-024 Throughput SHALL be one write per 2 cycles and one read per 3 cycles.
REQ-025 Outside ISSUE, ram_en and ram_we SHALL be 0; ram_addr and ram_wdata SHALL hold their last values.
REQ-026 The losing requester SHALL NOT receive ack and SHALL be re-arbitrated at the next IDLE.
REQ-027 Requesters SHALL hold req and command stable until ack; a req dropped after latching SHALL NOT abort the access.
REQ-028 A req still high in the cycle after ack SHALL be treated as a new request.
REQ-029 ack_a and ack_b SHALL never be high together; likewise rvalid_a and rvalid_b.
REQ-030 The read data path SHALL NOT alter data: rdata equals ram_rdata bit-for-bit.
REQ-031 rvalid SHALL NOT pulse for writes.

Reset
REQ-032 While rst=0, state SHALL be IDLE and ack_*, rvalid_*, ram_en, ram_we and busy SHALL be 0.
REQ-033 While rst=0, ram_addr, ram_wdata and rdata_* SHALL be 0, and the pointer SHALL be set so that A wins the first contention.
REQ-034 Reset asserted mid-ISSUE or mid-CAPTURE SHALL abort the access immediately, with no later ack or rvalid for it.

Verification
REQ-035 Single write: A writes 0x5A to addr 3 -> ack_a one cycle later with ram_en=1, ram_we=1, ram_addr=3, ram_wdata=0x5A; no rvalid.
REQ-036 Single read: B reads addr 3 after the write above -> ack_b, then rvalid_b 3 cycles after the req-sampling edge with rdata_b=0x5A.
REQ-037 Contention: req_a and req_b held with writes after reset -> grants alternate A,B,A,B on successive ISSUE cycles, 2 cycles apart.
REQ-038 Back-to-back reads: A reads addr 0 then addr 15 with req held -> two rvalid_a pulses 3 cycles apart with correct data; busy stays 1 through both accesses except in the IDLE cycles between them.
REQ-039 Reset mid-read: rst=0 during CAPTURE -> outputs take reset values immediately, no rvalid; after release, the first contention grants A.
REQ-040 Idle: no req for 10 cycles -> ram_en stays 0 and busy stays 0.
